// File: rtl/semafor_ctrl_pkg.sv
// Shared definitions for the traffic-light controller: state codes,
// lamp encodings and the request-eligibility helper.
package semafor_ctrl_pkg;

    // State codes, also exported on faza for debug. Code 3'd7 is unused.
    typedef enum logic [2:0] {
        S_VERDE    = 3'd0,
        S_GALBEN   = 3'd1,
        S_ALL_RED  = 3'd2,
        S_PIETONI  = 3'd3,
        S_CLIP     = 3'd4,
        S_ALL_RED2 = 3'd5,
        S_NOAPTE   = 3'd6
    } state_t;

    // Car lamps are {rosu, galben, verde}
    localparam logic [2:0] LED_ROSU   = 3'b100;
    localparam logic [2:0] LED_GALBEN = 3'b010;
    localparam logic [2:0] LED_VERDE  = 3'b001;
    localparam logic [2:0] LED_STINS  = 3'b000;

    // Pedestrian lamp: 1 = red, 0 = green
    localparam logic PIET_ROSU  = 1'b1;
    localparam logic PIET_VERDE = 1'b0;

    // A button press is only remembered while no pedestrian phase is in
    // progress or imminent.
    function automatic logic req_eligible(input state_t s);
        return (s == S_VERDE) || (s == S_GALBEN) ||
               (s == S_ALL_RED2) || (s == S_NOAPTE);
    endfunction

endpackage

// File: rtl/semafor_ctrl_if.sv
// Board-side signal bundle of the traffic-light controller: the two
// request inputs and the lamp / status outputs.
interface semafor_ctrl_if;

    logic       buton;
    logic       mod_noapte;
    logic [2:0] led_masini;
    logic       led_pietoni;
    logic       cerere_activa;
    logic [2:0] faza;

    // Board / stimulus side
    modport master (
        output buton,
        output mod_noapte,
        input  led_masini,
        input  led_pietoni,
        input  cerere_activa,
        input  faza
    );

    // Controller side
    modport slave (
        input  buton,
        input  mod_noapte,
        output led_masini,
        output led_pietoni,
        output cerere_activa,
        output faza
    );

endinterface

// File: rtl/semafor_tick.sv
// Prescaler producing a one-clock enable every CLK_DIV clocks
// (one tick per second at the board clock rate).
module semafor_tick #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;

    // Free-running 0..CLK_DIV-1 counter, wraps right after the tick clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == LAST);

endmodule

// File: rtl/semafor_ctrl.sv
// Traffic-light controller for one car lane and one pedestrian crossing,
// with latched pedestrian requests and a blinking-yellow night mode.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  S_VERDE    | cars green, waits >= T_VERDE_MIN ticks for a request
//  S_GALBEN   | cars yellow
//  S_ALL_RED  | clearance before pedestrians go
//  S_PIETONI  | pedestrians steady green
//  S_CLIP     | pedestrians blinking green
//  S_ALL_RED2 | clearance before cars go (reset state)
//  S_NOAPTE   | night mode, car yellow blinking, pedestrians red
module semafor_ctrl
    import semafor_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 50_000_000,
    parameter int TW          = 8,
    parameter int T_VERDE_MIN = 60,
    parameter int T_GALBEN    = 5,
    parameter int T_CLEAR     = 2,
    parameter int T_PIETONI   = 30,
    parameter int T_CLIP      = 6
) (
    input logic           clk,
    input logic           rst,
    semafor_ctrl_if.slave bus
);

    // Terminal-count values: the state is left on the tick seeing timer==T-1
    localparam logic [TW-1:0] TC_VERDE   = TW'(T_VERDE_MIN - 1);
    localparam logic [TW-1:0] SAT_VERDE  = TW'(T_VERDE_MIN);
    localparam logic [TW-1:0] TC_GALBEN  = TW'(T_GALBEN - 1);
    localparam logic [TW-1:0] TC_CLEAR   = TW'(T_CLEAR - 1);
    localparam logic [TW-1:0] TC_PIETONI = TW'(T_PIETONI - 1);
    localparam logic [TW-1:0] TC_CLIP    = TW'(T_CLIP - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          blink;
    logic          cerere;
    logic          tick;
    logic          enter_piet;

    semafor_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign enter_piet = tick && (state == S_ALL_RED) && (timer == TC_CLEAR);

    // Phase sequencing, phase timer and blink phase; all moves happen on ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ALL_RED2;
            timer <= '0;
            blink <= 1'b0;
        end else begin
            case (state)
                S_VERDE: begin
                    if (tick) begin
                        if (bus.mod_noapte) begin
                            // yellow lights on the first night tick
                            state <= S_NOAPTE;
                            timer <= '0;
                            blink <= 1'b1;
                        end else if (cerere && (timer >= TC_VERDE)) begin
                            state <= S_GALBEN;
                            timer <= '0;
                        end else if (timer < SAT_VERDE) begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_GALBEN: begin
                    if (tick) begin
                        if (timer == TC_GALBEN) begin
                            state <= S_ALL_RED;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_ALL_RED: begin
                    if (tick) begin
                        if (timer == TC_CLEAR) begin
                            state <= S_PIETONI;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_PIETONI: begin
                    if (tick) begin
                        if (timer == TC_PIETONI) begin
                            state <= S_CLIP;
                            timer <= '0;
                            blink <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_CLIP: begin
                    if (tick) begin
                        if (timer == TC_CLIP) begin
                            state <= S_ALL_RED2;
                            timer <= '0;
                            blink <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                            blink <= ~blink;
                        end
                    end
                end
                S_ALL_RED2: begin
                    if (tick) begin
                        if (timer == TC_CLEAR) begin
                            state <= bus.mod_noapte ? S_NOAPTE : S_VERDE;
                            timer <= '0;
                            blink <= bus.mod_noapte;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_NOAPTE: begin
                    if (tick) begin
                        if (!bus.mod_noapte) begin
                            state <= S_ALL_RED2;
                            blink <= 1'b0;
                        end else begin
                            blink <= ~blink;
                        end
                        timer <= '0;
                    end
                end
                default: begin
                    state <= S_ALL_RED2;
                    timer <= '0;
                    blink <= 1'b0;
                end
            endcase
        end
    end

    // Pedestrian request latch; clearing on pedestrian-green entry wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cerere <= 1'b0;
        end else if (enter_piet) begin
            cerere <= 1'b0;
        end else if (bus.buton && req_eligible(state)) begin
            cerere <= 1'b1;
        end
    end

    // Lamp decode from state and blink only
    always_comb begin
        bus.led_masini  = LED_ROSU;
        bus.led_pietoni = PIET_ROSU;
        case (state)
            S_VERDE:   bus.led_masini  = LED_VERDE;
            S_GALBEN:  bus.led_masini  = LED_GALBEN;
            S_PIETONI: bus.led_pietoni = PIET_VERDE;
            S_CLIP:    bus.led_pietoni = blink;
            S_NOAPTE:  bus.led_masini  = blink ? LED_GALBEN : LED_STINS;
            default:   ;
        endcase
    end

    assign bus.cerere_activa = cerere;
    assign bus.faza          = state;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Directed bench for semafor_ctrl with a 4-clock tick and short phases.
// Edge numbers below count clk rising edges since the last reset release;
// with CLK_DIV=4 the ticks fall on edges 4, 8, 12, ...
module tb_semafor_ctrl;

    localparam logic [2:0] F_VERDE = 3'd0, F_GALBEN = 3'd1, F_ALL_RED = 3'd2,
                           F_PIET = 3'd3, F_CLIP = 3'd4, F_ALL_RED2 = 3'd5,
                           F_NOAPTE = 3'd6;

    logic clk = 1'b0;
    logic rst;
    int   ecnt;
    int   n_assert = 0;
    int   n_fail   = 0;

    semafor_ctrl_if bus ();

    semafor_ctrl #(
        .CLK_DIV     (4),
        .TW          (8),
        .T_VERDE_MIN (6),
        .T_GALBEN    (2),
        .T_CLEAR     (1),
        .T_PIETONI   (4),
        .T_CLIP      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter for the step schedule, restarts with every reset
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Advance to 1 ns after edge e
    task automatic at_edge(input int e);
        int guard;
        guard = 0;
        while (ecnt < e && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt < e) begin
            n_assert++;
            n_fail++;
            $display("FAIL at_edge timeout: reached %0d, required %0d", ecnt, e);
        end
    endtask

    task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] led, input logic ped,
                       input logic cer, input logic [2:0] fz);
        chk1({tag, ".led_masini"},    {5'd0, bus.led_masini},    {5'd0, led});
        chk1({tag, ".led_pietoni"},   {7'd0, bus.led_pietoni},   {7'd0, ped});
        chk1({tag, ".cerere_activa"}, {7'd0, bus.cerere_activa}, {7'd0, cer});
        chk1({tag, ".faza"},          {5'd0, bus.faza},          {5'd0, fz});
    endtask

    initial begin
        rst = 1'b0;
        bus.buton = 1'b0;
        bus.mod_noapte = 1'b0;
        #1 rst = 1'b1;
        #9 chk("in_reset", 3'b100, 1'b1, 1'b0, F_ALL_RED2);
        #2 rst = 1'b0;

        // 1: all-red for 4 clocks after release, then green
        at_edge(1);  chk("t1_e1",  3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(3);  chk("t1_e3",  3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(4);  chk("t1_e4",  3'b001, 1'b1, 1'b0, F_VERDE);

        // 2: one-clock press during the second green tick, full ped cycle
        at_edge(9);  chk("t2_pre", 3'b001, 1'b1, 1'b0, F_VERDE);
        bus.buton = 1'b1;
        at_edge(10); chk("t2_latch", 3'b001, 1'b1, 1'b1, F_VERDE);
        bus.buton = 1'b0;
        at_edge(27); chk("t2_green_end", 3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(28); chk("t2_yel0",  3'b010, 1'b1, 1'b1, F_GALBEN);
        at_edge(35); chk("t2_yel1",  3'b010, 1'b1, 1'b1, F_GALBEN);
        at_edge(36); chk("t2_ared",  3'b100, 1'b1, 1'b1, F_ALL_RED);
        at_edge(39); chk("t2_ared1", 3'b100, 1'b1, 1'b1, F_ALL_RED);
        at_edge(40); chk("t2_piet0", 3'b100, 1'b0, 1'b0, F_PIET);
        at_edge(55); chk("t2_piet1", 3'b100, 1'b0, 1'b0, F_PIET);
        at_edge(56); chk("t2_clip0", 3'b100, 1'b0, 1'b0, F_CLIP);
        at_edge(60); chk("t2_clip1", 3'b100, 1'b1, 1'b0, F_CLIP);
        at_edge(64); chk("t2_ared2", 3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(67); chk("t2_ared2b", 3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(68); chk("t2_green", 3'b001, 1'b1, 1'b0, F_VERDE);
        at_edge(108); chk("t1_stay_green", 3'b001, 1'b1, 1'b0, F_VERDE);

        // 3: button held through a whole cycle, relatched in S_ALL_RED2
        bus.buton = 1'b1;
        at_edge(109); chk("t3_latch",  3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(112); chk("t3_yel",    3'b010, 1'b1, 1'b1, F_GALBEN);
        at_edge(120); chk("t3_ared",   3'b100, 1'b1, 1'b1, F_ALL_RED);
        at_edge(124); chk("t3_piet",   3'b100, 1'b0, 1'b0, F_PIET);
        at_edge(147); chk("t3_clip",   3'b100, 1'b1, 1'b0, F_CLIP);
        at_edge(148); chk("t3_ared2",  3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(149); chk("t3_relatch", 3'b100, 1'b1, 1'b1, F_ALL_RED2);
        at_edge(150); bus.buton = 1'b0;
        at_edge(152); chk("t3_green",  3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(175); chk("t3_green6", 3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(176); chk("t3_served", 3'b010, 1'b1, 1'b1, F_GALBEN);
        at_edge(216); chk("t3_back",   3'b001, 1'b1, 1'b0, F_VERDE);

        // 4: night mode with a pending request
        at_edge(217); bus.buton = 1'b1;
        at_edge(218); bus.buton = 1'b0; bus.mod_noapte = 1'b1;
        chk("t4_req", 3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(220); chk("t4_night0", 3'b010, 1'b1, 1'b1, F_NOAPTE);
        at_edge(224); chk("t4_night1", 3'b000, 1'b1, 1'b1, F_NOAPTE);
        at_edge(228); chk("t4_night2", 3'b010, 1'b1, 1'b1, F_NOAPTE);
        at_edge(229); bus.mod_noapte = 1'b0;
        at_edge(231); chk("t4_night3", 3'b010, 1'b1, 1'b1, F_NOAPTE);
        at_edge(232); chk("t4_ared2",  3'b100, 1'b1, 1'b1, F_ALL_RED2);
        at_edge(236); chk("t4_green",  3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(259); chk("t4_green6", 3'b001, 1'b1, 1'b1, F_VERDE);
        at_edge(260); chk("t4_served", 3'b010, 1'b1, 1'b1, F_GALBEN);
        at_edge(268); chk("t4_ared",   3'b100, 1'b1, 1'b1, F_ALL_RED);

        // 6: press coinciding with pedestrian-green entry leaves no request
        at_edge(269); bus.buton = 1'b1;
        at_edge(271); chk("t6_pre",   3'b100, 1'b1, 1'b1, F_ALL_RED);
        at_edge(272); chk("t6_entry", 3'b100, 1'b0, 1'b0, F_PIET);
        at_edge(273); chk("t6_held",  3'b100, 1'b0, 1'b0, F_PIET);
        bus.buton = 1'b0;

        // 5: asynchronous reset mid pedestrian green, seen before next edge
        at_edge(274);
        #2 rst = 1'b1;
        #1 chk("t5_async", 3'b100, 1'b1, 1'b0, F_ALL_RED2);
        #2 rst = 1'b0;
        at_edge(3); chk("t5_e3", 3'b100, 1'b1, 1'b0, F_ALL_RED2);
        at_edge(4); chk("t5_e4", 3'b001, 1'b1, 1'b0, F_VERDE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
